// File: rtl/jtkunio_gfx_romrq.sv
// SDRAM-side responder for one graphics ROM layer port, with a tag cache.
// Optional JTKUNIO_ROMRQ_CACHE2_EN: two-entry cache with 1-bit LRU replacement.
module jtkunio_gfx_romrq #(
  parameter int             AW     = 18,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = {SDW{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rom_cs,
  input  logic [AW-1:0]  rom_addr,
  output logic [31:0]    rom_data,
  output logic           rom_ok,
  output logic [SDW-1:0] sdram_addr,
  output logic           sdram_req,
  input  logic           sdram_ack,
  input  logic           sdram_rdy,
  input  logic [31:0]    sdram_din
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [AW-1:0]  pend_addr_r;
  logic           hit_s;
  logic [31:0]    hit_data_s;
  logic           start_s;
  logic           fill_s;
  logic           serve_s;
  logic           bypass_s;
  logic [SDW-1:0] addr_ext_s;

  assign addr_ext_s = SDW'(rom_addr);

`ifdef JTKUNIO_ROMRQ_CACHE2_EN
  logic [AW-1:0] tag_r [2];
  logic [31:0]   data_r [2];
  logic [1:0]    valid_r;
  logic          lru_r;   // entry to replace on the next fill
  logic          hit0_s;
  logic          hit1_s;

  assign hit0_s = valid_r[0] && (tag_r[0] == rom_addr);
  assign hit1_s = valid_r[1] && (tag_r[1] == rom_addr);

  // Two-entry hit detection and data select
  always_comb begin
    hit_s = hit0_s || hit1_s;
    if (hit0_s) begin
      hit_data_s = data_r[0];
    end else begin
      hit_data_s = data_r[1];
    end
  end

  // Cache storage: fills go to the LRU entry, hits mark the other one as victim
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r[0]  <= {AW{1'b0}};
      tag_r[1]  <= {AW{1'b0}};
      data_r[0] <= 32'h0;
      data_r[1] <= 32'h0;
      valid_r   <= 2'b00;
      lru_r     <= 1'b0;
    end else if (fill_s) begin
      tag_r[lru_r]   <= pend_addr_r;
      data_r[lru_r]  <= sdram_din;
      valid_r[lru_r] <= 1'b1;
      lru_r          <= ~lru_r;
    end else if (serve_s) begin
      lru_r <= hit0_s;
    end
  end
`else
  logic [AW-1:0] tag_r;
  logic [31:0]   data_r;
  logic          valid_r;

  // Single-entry hit detection
  always_comb begin
    hit_s      = valid_r && (tag_r == rom_addr);
    hit_data_s = data_r;
  end

  // Cache storage: every fill overwrites the single entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r   <= {AW{1'b0}};
      data_r  <= 32'h0;
      valid_r <= 1'b0;
    end else if (fill_s) begin
      tag_r   <= pend_addr_r;
      data_r  <= sdram_din;
      valid_r <= 1'b1;
    end
  end
`endif

  // Next-state logic; rdy without a prior ack in REQ is ignored unless ack comes with it
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    fill_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (rom_cs && !hit_s) begin
          next_state_s = REQ;
          start_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (sdram_ack && sdram_rdy) begin
          next_state_s = IDLE;
          fill_s       = 1'b1;
        end else if (sdram_ack) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT: begin
        if (sdram_rdy) begin
          next_state_s = IDLE;
          fill_s       = 1'b1;
        end else begin
          next_state_s = WAIT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Hits only count in IDLE; a completing fill is forwarded straight to the layer
  assign serve_s  = (state_r == IDLE) && rom_cs && hit_s;
  assign bypass_s = fill_s && rom_cs && (rom_addr == pend_addr_r);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered layer and SDRAM outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_addr_r <= {AW{1'b0}};
      sdram_addr  <= {SDW{1'b0}};
      sdram_req   <= 1'b0;
      rom_ok      <= 1'b0;
      rom_data    <= 32'h0;
    end else begin
      if (start_s) begin
        pend_addr_r <= rom_addr;
        sdram_addr  <= OFFSET + addr_ext_s;
      end
      if (start_s) begin
        sdram_req <= 1'b1;
      end else if ((state_r == REQ) && sdram_ack) begin
        sdram_req <= 1'b0;
      end
      rom_ok <= bypass_s || serve_s;
      if (bypass_s) begin
        rom_data <= sdram_din;
      end else if (serve_s) begin
        rom_data <= hit_data_s;
      end
    end
  end

endmodule

// File: tb/tb_jtkunio_gfx_romrq.sv
// Directed self-checking bench for jtkunio_gfx_romrq (OFFSET = 0x40000).
module tb_jtkunio_gfx_romrq;

  localparam int AW  = 18;
  localparam int SDW = 22;

  logic           clk = 1'b0;
  logic           rst;
  logic           rom_cs;
  logic [AW-1:0]  rom_addr;
  logic [31:0]    rom_data;
  logic           rom_ok;
  logic [SDW-1:0] sdram_addr;
  logic           sdram_req;
  logic           sdram_ack;
  logic           sdram_rdy;
  logic [31:0]    sdram_din;

  int errors = 0;
  int checks = 0;

  jtkunio_gfx_romrq #(.AW(AW), .SDW(SDW), .OFFSET(22'h40000)) dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_addr(sdram_addr),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .sdram_din(sdram_din)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents addr, waits (bounded) for req, acks, returns data; reports whether data came back.
  task automatic do_fetch(input logic [AW-1:0] a, input logic [31:0] d, output bit ok);
    bit seen = 1'b0;
    rom_cs   = 1'b1;
    rom_addr = a;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = (sdram_req === 1'b1);
    end
    ok = 1'b0;
    if (seen) begin
      sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
      step();
      sdram_rdy = 1'b1; sdram_din = d; step(); sdram_rdy = 1'b0;
      ok = (rom_ok === 1'b1) && (rom_data === d) && (sdram_req === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rom_cs = 1'b0; rom_addr = '0;
    sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_din = 32'h0;
    step(2);
    checks++;
    if (rom_ok !== 1'b0 || sdram_req !== 1'b0 || rom_data !== 32'h0 || sdram_addr !== 22'h0) begin
      errors++;
      $display("FAIL reset_values: ok=%b req=%b data=%h addr=%h want 0/0/0/0", rom_ok, sdram_req, rom_data, sdram_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    rom_cs = 1'b1; rom_addr = 18'h0123;
    step();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h40123 || rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL cold_req: req=%b addr=%h ok=%b want 1/40123/0", sdram_req, sdram_addr, rom_ok);
    end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    checks++;
    if (sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL cold_req_drop: req=%b want 0", sdram_req);
    end
    step(2);
    sdram_rdy = 1'b1; sdram_din = 32'hDEADBEEF; step(); sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cold_data: ok=%b data=%h want 1/deadbeef", rom_ok, rom_data);
    end
  endtask

  task automatic test_hit();
    rom_cs = 1'b0; step();
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL hit_cs_low: ok=%b want 0", rom_ok);
    end
    rom_cs = 1'b1; step();
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'hDEADBEEF || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_data: ok=%b data=%h req=%b want 1/deadbeef/0", rom_ok, rom_data, sdram_req);
    end
    step(3);
    checks++;
    if (sdram_req !== 1'b0 || rom_ok !== 1'b1) begin
      errors++;
      $display("FAIL hit_no_req: req=%b ok=%b want 0/1", sdram_req, rom_ok);
    end
  endtask

  task automatic test_addr_change();
    rom_addr = 18'h10; step();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h40010) begin
      errors++;
      $display("FAIL chg_req1: req=%b addr=%h want 1/40010", sdram_req, sdram_addr);
    end
    rom_addr = 18'h20;
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; sdram_din = 32'h11111111; step(); sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL chg_no_ok: ok=%b want 0", rom_ok);
    end
    step();
    checks++;
    if (sdram_req !== 1'b1 || sdram_addr !== 22'h40020 || rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL chg_req2: req=%b addr=%h ok=%b want 1/40020/0", sdram_req, sdram_addr, rom_ok);
    end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; sdram_din = 32'h22222222; step(); sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'h22222222) begin
      errors++;
      $display("FAIL chg_data2: ok=%b data=%h want 1/22222222", rom_ok, rom_data);
    end
  endtask

  task automatic test_ack_rdy_same();
    rom_addr = 18'h30; step();
    sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_din = 32'h33333333; step();
    sdram_ack = 1'b0; sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'h33333333 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL same_fill: ok=%b data=%h req=%b want 1/33333333/0", rom_ok, rom_data, sdram_req);
    end
    step(3);
    checks++;
    if (sdram_req !== 1'b0 || rom_ok !== 1'b1) begin
      errors++;
      $display("FAIL same_no_req2: req=%b ok=%b want 0/1", sdram_req, rom_ok);
    end
  endtask

  task automatic test_rdy_before_ack();
    rom_addr = 18'h40; step();
    sdram_rdy = 1'b1; sdram_din = 32'h00000BAD; step(); sdram_rdy = 1'b0;
    checks++;
    if (sdram_req !== 1'b1 || rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL early_rdy: req=%b ok=%b want 1/0", sdram_req, rom_ok);
    end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; sdram_din = 32'h44444444; step(); sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'h44444444) begin
      errors++;
      $display("FAIL early_rdy_data: ok=%b data=%h want 1/44444444", rom_ok, rom_data);
    end
  endtask

  task automatic test_cs_drop();
    rom_addr = 18'h50; step();
    rom_cs = 1'b0;
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; sdram_din = 32'h55555555; step(); sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL csdrop_ok: ok=%b want 0", rom_ok);
    end
    rom_cs = 1'b1; step();
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'h55555555 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL csdrop_hit: ok=%b data=%h req=%b want 1/55555555/0", rom_ok, rom_data, sdram_req);
    end
  endtask

  task automatic test_reset_mid_fetch();
    rom_addr = 18'h60; step();
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    rst = 1'b1; rom_cs = 1'b0; #1;
    checks++;
    if (rom_ok !== 1'b0 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: ok=%b req=%b want 0/0", rom_ok, sdram_req);
    end
    step(); rst = 1'b0; step();
    sdram_rdy = 1'b1; sdram_din = 32'h66666666; step(); sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b0 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_stray_rdy: ok=%b req=%b want 0/0", rom_ok, sdram_req);
    end
    rom_cs = 1'b1; rom_addr = 18'h50; step();
    checks++;
    if (sdram_req !== 1'b1 || rom_ok !== 1'b0 || sdram_addr !== 22'h40050) begin
      errors++;
      $display("FAIL rst_invalid: req=%b ok=%b addr=%h want 1/0/40050", sdram_req, rom_ok, sdram_addr);
    end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; sdram_din = 32'h50505050; step(); sdram_rdy = 1'b0;
  endtask

  task automatic test_cache_entries();
    bit ok;
    do_fetch(18'h100, 32'hAAAA0001, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fetch_A: ok=%b data=%h want 1/aaaa0001", rom_ok, rom_data); end
    do_fetch(18'h200, 32'hBBBB0002, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fetch_B: ok=%b data=%h want 1/bbbb0002", rom_ok, rom_data); end
    rom_addr = 18'h100; step();
`ifdef JTKUNIO_ROMRQ_CACHE2_EN
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'hAAAA0001 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL c2_hit_A: ok=%b data=%h req=%b want 1/aaaa0001/0", rom_ok, rom_data, sdram_req);
    end
    do_fetch(18'h300, 32'hCCCC0003, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fetch_C: ok=%b data=%h want 1/cccc0003", rom_ok, rom_data); end
    rom_addr = 18'h100; step();
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'hAAAA0001 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL c2_A_kept: ok=%b data=%h req=%b want 1/aaaa0001/0", rom_ok, rom_data, sdram_req);
    end
    rom_addr = 18'h200; step();
    checks++;
    if (sdram_req !== 1'b1 || rom_ok !== 1'b0) begin
      errors++;
      $display("FAIL c2_B_evicted: req=%b ok=%b want 1/0", sdram_req, rom_ok);
    end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; sdram_din = 32'hBBBB0002; step(); sdram_rdy = 1'b0;
    rom_addr = 18'h100; step();
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'hAAAA0001 || sdram_req !== 1'b0) begin
      errors++;
      $display("FAIL c2_A_final: ok=%b data=%h req=%b want 1/aaaa0001/0", rom_ok, rom_data, sdram_req);
    end
`else
    checks++;
    if (sdram_req !== 1'b1 || rom_ok !== 1'b0 || sdram_addr !== 22'h40100) begin
      errors++;
      $display("FAIL c1_A_evicted: req=%b ok=%b addr=%h want 1/0/40100", sdram_req, rom_ok, sdram_addr);
    end
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
    sdram_rdy = 1'b1; sdram_din = 32'hAAAA0001; step(); sdram_rdy = 1'b0;
    checks++;
    if (rom_ok !== 1'b1 || rom_data !== 32'hAAAA0001) begin
      errors++;
      $display("FAIL c1_A_refill: ok=%b data=%h want 1/aaaa0001", rom_ok, rom_data);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_addr_change();
    test_ack_rdy_same();
    test_rdy_before_ack();
    test_cs_drop();
    test_reset_mid_fetch();
    test_cache_entries();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
